// File: rtl/vdcm_fifo_pkg.sv
// Shared definitions for the VDCM RAM-backed FIFO controller.
// Contents:
//   SKID_DEPTH / SKID_CNT_W : depth of the output skid buffer and its counter width
//   ptr_w(lines)            : RAM pointer width, $clog2(lines)
//   cnt_w(lines)            : occupancy counter width, ptr_w(lines) + 2
//                             (must hold lines + SKID_DEPTH)
package vdcm_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  function automatic int ptr_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int cnt_w(input int lines);
    return $clog2(lines) + 2;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// Ports:
//   clk                 clock
//   w_en/addr_w/wr_data write port (write takes effect at the clock edge)
//   r_en/addr_r         read request
//   rd_data             read data, valid the cycle after r_en
//   mem_valid           r_en delayed one cycle (not reset)
module dp_ram #(
  parameter int NUMBER_OF_LINES = 8192,
  parameter int DATA_WIDTH      = 128
) (
  input  logic                               clk,
  input  logic                               w_en,
  input  logic [$clog2(NUMBER_OF_LINES)-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               r_en,
  input  logic [$clog2(NUMBER_OF_LINES)-1:0] addr_r,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               mem_valid
);

  logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr_w] <= wr_data;
    if (r_en) rd_data <= mem[addr_r];
    mem_valid <= r_en;
  end

endmodule

// File: rtl/ram_fifo_skid.sv
// Two-entry output skid buffer. Captures RAM read data and presents the
// oldest entry at head_data; a pop shifts entry 1 down into entry 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears the count only)
//   capture     load cap_data this cycle (RAM read returning)
//   cap_data    RAM read data
//   pop         consumer takes head_data this cycle
//   head_data   oldest held entry
//   count       number of held entries (0..2)
//   count_nxt   count after this cycle's capture/pop
module ram_fifo_skid
  import vdcm_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [SKID_CNT_W-1:0] count,
  output logic [SKID_CNT_W-1:0] count_nxt
);

  logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
  logic [SKID_CNT_W-1:0] count_after_pop;

  always_comb begin
    count_after_pop = count - SKID_CNT_W'(pop);
    count_nxt       = count_after_pop + SKID_CNT_W'(capture);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

  // Data is not reset: an entry is only observed once count covers it.
  // The shift happens first; the capture then lands in the first free slot
  // after the shift, so a same-cycle write to entry 0 overrides the shift.
  always_ff @(posedge clk) begin
    if (pop) entry[0] <= entry[1];
    if (capture) begin
      if (count_after_pop == '0) entry[0] <= cap_data;
      else                       entry[1] <= cap_data;
    end
  end

  assign head_data = entry[0];

  a_skid_bound : assert property (@(posedge clk) disable iff (rst)
    count_nxt <= SKID_CNT_W'(SKID_DEPTH));

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around one dp_ram, for line/rate buffering in the VDCM
// datapath. Upstream and downstream are ready/valid: a beat moves on a side
// in every cycle where both valid and ready are high; valid never depends on
// ready of the same side. The RAM's registered read is absorbed by a 2-entry
// skid buffer, giving one beat per cycle on both sides.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     write side
//   out_valid/out_ready/out_data  read side (out_data registered)
//   fill_level                    beats held: RAM + read in flight + skid
//   almost_full                   fill_level >= AF_THRESH (registered)
//   hwm                           max fill_level since reset; present only
//                                 when RAM_FIFO_HWM_EN is defined
module ram_fifo_ctrl
  import vdcm_fifo_pkg::*;
#(
  parameter int NUMBER_OF_LINES = 8192,
  parameter int DATA_WIDTH      = 128,
  parameter int AF_THRESH       = NUMBER_OF_LINES - 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [cnt_w(NUMBER_OF_LINES)-1:0]    fill_level,
  output logic                                 almost_full
`ifdef RAM_FIFO_HWM_EN
  ,
  output logic [cnt_w(NUMBER_OF_LINES)-1:0]    hwm
`endif
);

  localparam int PTR_W = ptr_w(NUMBER_OF_LINES);
  localparam int CNT_W = cnt_w(NUMBER_OF_LINES);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      ram_count, ram_count_nxt, fill_nxt;
  logic                  inflight;
  logic                  push, pop, r_en;
  logic [SKID_CNT_W-1:0] skid_count, skid_count_nxt;
  logic [2:0]            skid_claimed;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  ram_mem_valid_unused;

  always_comb begin
    in_ready  = (ram_count < CNT_W'(NUMBER_OF_LINES));
    out_valid = (skid_count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    // Skid slots that will be occupied next cycle before any new read; pop
    // implies skid_count > 0, so this cannot underflow.
    skid_claimed = 3'(skid_count) + 3'(inflight) - 3'(pop);
    // Registered ram_count excludes a same-cycle write, so the read address
    // never equals the address being written this cycle.
    r_en          = (ram_count != '0) && (skid_claimed < 3'd2);
    ram_count_nxt = ram_count + CNT_W'(push) - CNT_W'(r_en);
    fill_nxt      = ram_count_nxt + CNT_W'(r_en) + CNT_W'(skid_count_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      inflight    <= 1'b0;
      fill_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (r_en) rd_ptr <= rd_ptr + 1'b1;
      ram_count   <= ram_count_nxt;
      inflight    <= r_en;
      fill_level  <= fill_nxt;
      almost_full <= (fill_nxt >= CNT_W'(AF_THRESH));
    end
  end

`ifdef RAM_FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)                  hwm <= '0;
    else if (fill_level > hwm) hwm <= fill_level;
  end
`endif

  // mem_valid is unreset in the RAM, so occupancy and capture use the local
  // inflight register instead.
  dp_ram #(
    .NUMBER_OF_LINES (NUMBER_OF_LINES),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .w_en      (push),
    .addr_w    (wr_ptr),
    .wr_data   (in_data),
    .r_en      (r_en),
    .addr_r    (rd_ptr),
    .rd_data   (ram_rd_data),
    .mem_valid (ram_mem_valid_unused)
  );

  ram_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .capture   (inflight),
    .cap_data  (ram_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .count     (skid_count),
    .count_nxt (skid_count_nxt)
  );

endmodule
